// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    localparam int IF_XLEN    = 32;
    localparam int IF_ILEN    = 32;
    localparam int IF_DEPTH   = 4;
    localparam int IF_PC_STEP = 4;

    // One queue entry as seen by decode.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_ILEN-1:0] instr;
    } fetch_entry_t;

    // Pointer width: one extra bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response, redirect, and decode handshake.
// Latency: n/a (wires only).
// Backpressure: decode stalls the head via out_ready; imem always accepts requests.
// master = fetch unit, slave = environment (imem, branch unit, decode).
interface if_fetch_queue_if
    import if_pkg::*;
#(
    parameter int XLEN = IF_XLEN,
    parameter int ILEN = IF_ILEN
);
    logic            fetch_en;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        input  fetch_en, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output fetch_en, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_slot_ram.sv
// Slot storage for the fetch queue: pc written at issue, instr written at response.
// Latency: write visible on read port the cycle after the write edge; async read.
// Backpressure: none; the owner guarantees slot allocation.
// Ports: clk; pc write port; instr write port; one async read port (rd_pc, rd_instr).
module fetch_slot_ram #(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    parameter  int ILEN  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            pc_we,
    input  logic [AW-1:0]   pc_waddr,
    input  logic [XLEN-1:0] pc_wdata,
    input  logic            instr_we,
    input  logic [AW-1:0]   instr_waddr,
    input  logic [ILEN-1:0] instr_wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rd_pc,
    output logic [ILEN-1:0] rd_instr
);
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    // Contents need no reset: a slot is only read once its fill pointer has passed it.
    always_ff @(posedge clk) begin
        if (pc_we) begin
            pc_mem[pc_waddr] <= pc_wdata;
        end
        if (instr_we) begin
            instr_mem[instr_waddr] <= instr_wdata;
        end
    end

    assign rd_pc    = pc_mem[raddr];
    assign rd_instr = instr_mem[raddr];
endmodule

// File: rtl/if_fetch_queue.sv
// In-order instruction prefetch queue: owns the PC, issues imem requests, hands {pc,instr} to decode.
// Latency: 1-cycle imem gives out_valid 2 cycles after the first imem_req, then 1 instr/cycle.
// Backpressure: out_ready low holds the head; queue full (DEPTH reserved slots) stalls issue.
// Ports: clk, reset (sync, active-high); bus (master): fetch_en, imem_*, redirect_*, out_*.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int              XLEN     = IF_XLEN,
    parameter int              ILEN     = IF_ILEN,
    parameter int              DEPTH    = IF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = IF_PC_STEP
) (
    input  logic          clk,
    input  logic          reset,
    if_fetch_queue_if.master bus
);
    localparam int              PW         = ptr_w(DEPTH);
    localparam int              AW         = PW - 1;
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [PW-1:0]   DEPTH_P    = PW'(DEPTH);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP - 1));

    logic [XLEN-1:0] pc;
    logic [PW-1:0]   alloc_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   read_ptr;
    logic [PW-1:0]   drop_cnt;
    logic [XLEN-1:0] hold_pc;
    logic [ILEN-1:0] hold_instr;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;
    logic [PW-1:0]   occupancy;
    logic            issue;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            rsp_used;
    logic            head_vld;
    logic            pop;

    // Occupancy counts reserved slots, so a same-cycle pop never frees room for issue.
    assign occupancy = alloc_ptr - read_ptr;
    assign issue     = ~reset & bus.fetch_en & ~bus.redirect_valid & (occupancy < DEPTH_P);

    // Responses belonging to flushed requests are consumed first; a response with
    // nothing outstanding is ignored.
    assign rsp_drop  = bus.imem_rvalid & (drop_cnt != '0);
    assign rsp_fill  = bus.imem_rvalid & (drop_cnt == '0) & (fill_ptr != alloc_ptr);
    assign rsp_used  = rsp_drop | rsp_fill;

    assign head_vld  = (fill_ptr != read_ptr);
    assign pop       = head_vld & bus.out_ready & ~bus.redirect_valid;

    fetch_slot_ram #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .ILEN  (ILEN)
    ) u_slot_ram (
        .clk         (clk),
        .pc_we       (issue),
        .pc_waddr    (alloc_ptr[AW-1:0]),
        .pc_wdata    (pc),
        .instr_we    (rsp_fill & ~reset & ~bus.redirect_valid),
        .instr_waddr (fill_ptr[AW-1:0]),
        .instr_wdata (bus.imem_rdata),
        .raddr       (read_ptr[AW-1:0]),
        .rd_pc       (head_pc),
        .rd_instr    (head_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            read_ptr   <= '0;
            drop_cnt   <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            // Remember what decode last saw so the bus holds steady while empty.
            if (head_vld) begin
                hold_pc    <= head_pc;
                hold_instr <= head_instr;
            end
            if (bus.redirect_valid) begin
                pc        <= bus.redirect_pc & ALIGN_MASK;
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                read_ptr  <= '0;
                // Everything still outstanding becomes a drop; a response arriving
                // now is already accounted for by this cycle.
                drop_cnt  <= drop_cnt + (alloc_ptr - fill_ptr) - PW'(rsp_used);
            end else begin
                if (issue) begin
                    alloc_ptr <= alloc_ptr + PTR_ONE;
                    pc        <= pc + STEP;
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - PTR_ONE;
                end
                if (rsp_fill) begin
                    fill_ptr <= fill_ptr + PTR_ONE;
                end
                if (pop) begin
                    read_ptr <= read_ptr + PTR_ONE;
                end
            end
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = head_vld;
    assign bus.out_pc    = head_vld ? head_pc    : hold_pc;
    assign bus.out_instr = head_vld ? head_instr : hold_instr;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a fixed-latency in-order imem model.
// Latency: imem response latency selectable per scenario (mem_lat).
// Backpressure: out_ready driven per scenario to exercise stall and release.
module tb_if_fetch_queue;
    import if_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_fetch_queue_if bus ();

    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = '0;
    assign bus.imem_rvalid = mem_rvalid;
    assign bus.imem_rdata  = mem_rdata;

    if_fetch_queue #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int          due_q  [$];
    logic [31:0] addr_q [$];

    // Memory image: every word is its address xor a tag.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // imem model: requests seen mid-cycle, answered mem_lat cycles later, in order.
    always @(negedge clk) begin
        cyc = cyc + 1;
        mem_rvalid = 1'b0;
        if (reset) begin
            due_q.delete();
            addr_q.delete();
        end else begin
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(addr_q[0]);
                void'(due_q.pop_front());
                void'(addr_q.pop_front());
            end
            if (bus.imem_req) begin
                due_q.push_back(cyc + mem_lat);
                addr_q.push_back(bus.imem_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_vld"},   bus.out_valid, 1);
        check_eq({tag, "_pc"},    bus.out_pc,    pc);
        check_eq({tag, "_instr"}, bus.out_instr, pc ^ 32'hC0DE_0000);
    endtask

    fetch_entry_t release_tab [5];
    int nreq;

    initial begin
        release_tab[0] = '{pc: 32'h0,  instr: 32'hC0DE_0000};
        release_tab[1] = '{pc: 32'h4,  instr: 32'hC0DE_0004};
        release_tab[2] = '{pc: 32'h8,  instr: 32'hC0DE_0008};
        release_tab[3] = '{pc: 32'hC,  instr: 32'hC0DE_000C};
        release_tab[4] = '{pc: 32'h10, instr: 32'hC0DE_0010};

        // ---- reset values, then streaming with 1-cycle memory ----
        reset              = 1'b1;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        mem_lat            = 1;
        step();
        step();
        #1;
        check_eq("rst_imem_req",  bus.imem_req,  0);
        check_eq("rst_imem_addr", bus.imem_addr, 32'h0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_pc",    bus.out_pc,    32'h0);
        check_eq("rst_out_instr", bus.out_instr, 32'h0);
        step();
        reset        = 1'b0;
        bus.fetch_en = 1'b1;
        #1;
        check_eq("t1_req_c0",  bus.imem_req,  1);
        check_eq("t1_addr_c0", bus.imem_addr, 32'h0);
        check_eq("t1_vld_c0",  bus.out_valid, 0);
        step(); #1;
        check_eq("t1_addr_c1", bus.imem_addr, 32'h4);
        check_eq("t1_vld_c1",  bus.out_valid, 0);
        step(); #1;
        expect_head("t1_c2", 32'h0);
        for (int i = 1; i < 4; i++) begin
            step(); #1;
            expect_head($sformatf("t1_c%0d", i + 2), 32'(4 * i));
        end

        // ---- decode stalled: fill to DEPTH, then release ----
        do_reset();
        bus.out_ready = 1'b0;
        bus.fetch_en  = 1'b1;
        #1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req) begin
                check_eq($sformatf("t2_addr%0d", nreq), bus.imem_addr, 32'(4 * nreq));
                nreq++;
            end
            if (bus.out_valid) begin
                check_eq($sformatf("t2_head_hold%0d", i), bus.out_pc, 32'h0);
            end
            step(); #1;
        end
        check_eq("t2_req_count",   nreq,          4);
        check_eq("t2_req_stalled", bus.imem_req,  0);
        bus.out_ready = 1'b1;
        #1;
        check_eq("t2_no_ready_path", bus.imem_req, 0);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t2_rel%0d_vld", i),   bus.out_valid, 1);
            check_eq($sformatf("t2_rel%0d_pc", i),    bus.out_pc,    release_tab[i].pc);
            check_eq($sformatf("t2_rel%0d_instr", i), bus.out_instr, release_tab[i].instr);
            step(); #1;
        end

        // ---- redirect with 3 outstanding on 3-cycle memory ----
        do_reset();
        mem_lat       = 3;
        bus.out_ready = 1'b1;
        bus.fetch_en  = 1'b1;
        #1;
        step(); #1;
        step(); #1;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        check_eq("t3_no_issue_redirect", bus.imem_req, 0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("t3_req_target",  bus.imem_req,  1);
        check_eq("t3_addr_target", bus.imem_addr, 32'h100);
        for (int i = 5; i < 8; i++) begin
            step(); #1;
            check_eq($sformatf("t3_drop_c%0d", i), bus.out_valid, 0);
        end
        step(); #1;
        expect_head("t3_first", 32'h100);
        step(); #1;
        expect_head("t3_second", 32'h104);

        // ---- redirect coincident with response and pop ----
        do_reset();
        mem_lat       = 1;
        bus.out_ready = 1'b1;
        bus.fetch_en  = 1'b1;
        #1;
        step(); #1;
        step(); #1;
        expect_head("t4_c2", 32'h0);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        expect_head("t4_c3", 32'h4);
        check_eq("t4_no_issue", bus.imem_req, 0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("t4_vld_after",  bus.out_valid, 0);
        check_eq("t4_hold_pc",    bus.out_pc,    32'h4);
        check_eq("t4_hold_instr", bus.out_instr, 32'hC0DE_0004);
        check_eq("t4_addr",       bus.imem_addr, 32'h200);
        step(); #1;
        check_eq("t4_vld_c5", bus.out_valid, 0);
        step(); #1;
        expect_head("t4_target", 32'h200);
        step(); #1;
        expect_head("t4_next", 32'h204);

        // ---- redirect alignment and PC wrap ----
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("t5_align_req",  bus.imem_req,  1);
        check_eq("t5_align_addr", bus.imem_addr, 32'h100);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        #1;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("t5_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step(); #1;
        check_eq("t5_wrap_req",  bus.imem_req,  1);
        check_eq("t5_wrap_addr", bus.imem_addr, 32'h0);
        step(); #1;
        check_eq("t5_top_instr", bus.out_instr, 32'h3F21_FFFC);
        expect_head("t5_top", 32'hFFFF_FFFC);
        step(); #1;
        expect_head("t5_wrapped", 32'h0);

        // ---- reset while the queue holds entries ----
        do_reset();
        mem_lat       = 1;
        bus.out_ready = 1'b0;
        bus.fetch_en  = 1'b1;
        #1;
        step(); #1;
        step();
        bus.out_ready = 1'b1;
        #1;
        step();
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        #1;
        expect_head("t6_pre", 32'h4);
        step(); #1;
        check_eq("t6_rst_req",   bus.imem_req,  0);
        check_eq("t6_rst_addr",  bus.imem_addr, 32'h0);
        check_eq("t6_rst_vld",   bus.out_valid, 0);
        check_eq("t6_rst_pc",    bus.out_pc,    32'h0);
        check_eq("t6_rst_instr", bus.out_instr, 32'h0);
        step();
        reset = 1'b0;
        #1;
        check_eq("t6_restart_req",  bus.imem_req,  1);
        check_eq("t6_restart_addr", bus.imem_addr, 32'h0);
        step(); #1;
        check_eq("t6_vld_c1", bus.out_valid, 0);
        step(); #1;
        expect_head("t6_restart", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
